scrambler_seq: RTL and testbench
================================

Name: scrambler_seq

Overview:
- Frame-level sequencer for the 802.11a scrambler.
- On `start` it loads the scrambler seed, then streams one serial bit per cycle on the scrambler input in this order:
  - 16 SERVICE zero bits
  - PSDU bits, LSB first, pulled byte-wise from the MAC-side handshake
  - 6 tail zero bits
  - zero pad bits up to a multiple of N_DBPS
- Flags the scrambled tail bits so downstream forces them to zero before the convolutional encoder.
- Sits between the MAC byte interface and the scrambler.

Parameters:
- LEN_W, 12, width of PSDU length in bytes (max 4095).
- NDBPS_W, 8, width of the per-frame data-bits-per-symbol input (max 216 fits).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse; ignored while busy=1
- psdu_len  in  LEN_W  PSDU length in bytes, sampled on accepted start
- ndbps  in  NDBPS_W  data bits per OFDM symbol (24..216), sampled on accepted start
- seed  in  7  scrambler initial state, sampled on accepted start
- byte_data  in  8  PSDU byte
- byte_valid  in  1  byte_data valid
- byte_ready  out  1  sequencer accepts byte when byte_valid&byte_ready
- scr_reset  out  1  to scrambler reset input
- scr_init  out  7  to scrambler initial-state input
- scr_din  out  1  serial bit to scrambler
- scr_din_valid  out  1  scrambler input valid
- tail_zero  out  1  high on the cycles the scrambler output carries a tail bit
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when the last scrambled bit is valid at the scrambler output

Behaviour:
- Reset (async, reset_n=0):
  - FSM goes to IDLE.
  - All outputs and counters are 0, except scr_init=7'h7F.
- FSM states: IDLE, INIT, SERVICE, DATA, TAIL, PAD, FLUSH.
- IDLE:
  - start=1 latches psdu_len, ndbps and seed.
  - If seed==0, 7'h7F is latched instead; the scrambler must never be all-zero.
  - busy=1 from the next cycle; go to INIT.
- INIT: one cycle with scr_reset=1 and scr_init=latched seed; go to SERVICE.
- Timing anchor: start sampled at edge k → scr_reset high in cycle k+1 → first SERVICE bit valid in cycle k+2.
- SERVICE: 16 cycles, scr_din=0, scr_din_valid=1. Then go to DATA, or to TAIL if psdu_len==0.
- DATA: one-byte shift buffer with bits_left counter (0..8).
  - byte_ready = (state==DATA) && bytes_remaining!=0 && bits_left<=1.
  - An accepted byte loads the buffer. Loading in the same cycle the last bit is emitted gives gapless streaming.
  - When bits_left>0: emit buffer bit0 with scr_din_valid=1, then shift right.
  - When bits_left==0 (MAC stall): scr_din_valid=0. The scrambler holds state, so stalls never corrupt the sequence.
  - Go to TAIL after the last bit of the last byte is emitted.
- TAIL: 6 cycles, scr_din=0, valid=1.
- PAD: emit zero bits while the symbol bit counter sym_cnt≠0.
  - sym_cnt counts valid bits modulo the latched ndbps and starts at 0 with the first SERVICE bit.
  - If sym_cnt==0 on entry, PAD is skipped.
  - Latched ndbps==0 means no padding.
- FLUSH: one cycle (scrambler latency); done=1, busy=0 next cycle, return to IDLE.
- tail_zero: registered copy of "TAIL-state valid bit", i.e. high exactly 6 cycles, one cycle after each tail scr_din_valid, aligned with the scrambler output.
- Total valid bits = ceil((22+8·len)/ndbps)·ndbps.
- start during busy: ignored, no effect.
- byte_valid outside DATA: ignored; byte_ready stays 0.
- Reset mid-frame: immediate abort to IDLE, no done pulse.

Optional Feature:
- SCRSEQ_AUTO_SEED_EN
- Defined:
  - seed port is ignored.
  - Internal 7-bit seed register resets to 7'h5D.
  - It is used at each INIT, then advanced one step of x^7+x^4+1 ({s[5:0], s[6]^s[3]}) in the FLUSH cycle.
- Not defined: seed port used as described in Behaviour (zero maps to 7'h7F).

Decomposition:
- Package scr_pkg:
  - FSM state enum
  - SERVICE_BITS=16, TAIL_BITS=6
  - SEED_ZERO_SUB=7'h7F, AUTO_SEED_RST=7'h5D
  - LFSR step function
- One natural sub-module: psdu_serializer, which holds the byte buffer, bits_left, bytes_remaining and byte_ready.
- The scrambler itself is instantiated by the parent, not inside this block.

Test Plan:
- len=1, ndbps=24, seed=7'h5D, byte 0xA5 always valid:
  - scr_reset in cycle k+1.
  - 48 valid bits: 16×0, then 1,0,1,0,0,1,0,1, then 6×0, then 18 pad zeros.
  - done at cycle k+2+48.
- len=0, ndbps=24: DATA skipped, 22 bits + 2 pad = 24 valid bits; tail_zero high 6 cycles, delayed by 1.
- len=3, ndbps=24, byte_valid dropped for 3 cycles mid-byte-2: exactly 3 valid-low cycles, bit order intact, total 48 bits.
- seed=0: scr_init=7'h7F during INIT. Second start pulse while busy: no restart, single done.
- reset_n low during DATA: all outputs 0 asynchronously; next start runs a full, correct frame.
- SCRSEQ_AUTO_SEED_EN, two back-to-back frames: scr_init = 7'h5D then 7'h3A.

Source files
------------

// File: rtl/scr_pkg.sv
// Shared definitions for the 802.11a scrambler frame sequencer.
// Build option: SCRSEQ_AUTO_SEED_EN selects the internal rotating seed.
package scr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SERVICE = 3'd2,
        ST_DATA    = 3'd3,
        ST_TAIL    = 3'd4,
        ST_PAD     = 3'd5,
        ST_FLUSH   = 3'd6
    } state_e;

    localparam int SERVICE_BITS = 16;
    localparam int TAIL_BITS    = 6;

    // An all-zero scrambler state would lock up, so a zero seed is replaced.
    localparam logic [6:0] SEED_ZERO_SUB = 7'h7F;
    localparam logic [6:0] AUTO_SEED_RST = 7'h5D;

    // One step of the x^7+x^4+1 seed generator.
    function automatic logic [6:0] lfsr_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[3]};
    endfunction

endpackage

// File: rtl/scrambler_seq_psdu_serializer.sv
// Byte-to-bit serializer for the PSDU field: one-byte shift buffer, bit and
// byte bookkeeping, and the MAC-side ready. A byte arriving while the buffer
// is empty is emitted through the bypass in the same cycle, and a byte taken
// while the last buffered bit goes out refills the buffer, so a MAC that
// keeps byte_valid high sees a gapless bit stream.
module psdu_serializer
    import scr_pkg::*;
#(
    parameter int LEN_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             active_i,
    input  logic [7:0]       byte_data_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    output logic             bit_o,
    output logic             bit_valid_o,
    output logic             last_o
);

    logic [7:0]       shift_q, shift_d;
    logic [3:0]       bits_left_q, bits_left_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             accept;

    assign byte_ready_o = active_i && (rem_q != '0) && (bits_left_q <= 4'd1);
    assign accept       = byte_ready_o && byte_valid_i;
    assign bit_valid_o  = active_i && ((bits_left_q != 4'd0) || accept);
    assign bit_o        = (bits_left_q != 4'd0) ? shift_q[0] : byte_data_i[0];
    assign last_o       = active_i && (bits_left_q == 4'd1) && (rem_q == '0);

    // Next buffer state: frame load, byte load (bypass or refill), or shift.
    always_comb begin
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        rem_d       = rem_q;
        if (load_i) begin
            shift_d     = 8'd0;
            bits_left_d = 4'd0;
            rem_d       = len_i;
        end else if (accept) begin
            rem_d = rem_q - LEN_W'(1);
            if (bits_left_q == 4'd0) begin
                shift_d     = {1'b0, byte_data_i[7:1]};
                bits_left_d = 4'd7;
            end else begin
                shift_d     = byte_data_i;
                bits_left_d = 4'd8;
            end
        end else if (active_i && (bits_left_q != 4'd0)) begin
            shift_d     = {1'b0, shift_q[7:1]};
            bits_left_d = bits_left_q - 4'd1;
        end
    end

    // Buffer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q     <= 8'd0;
            bits_left_q <= 4'd0;
            rem_q       <= '0;
        end else begin
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
            rem_q       <= rem_d;
        end
    end

endmodule

// File: rtl/scrambler_seq.sv
// 802.11a scrambler frame sequencer: SERVICE, PSDU, tail and pad bits
// streamed serially into an external scrambler, one bit per cycle.
// Build option: SCRSEQ_AUTO_SEED_EN ignores the seed port and uses an
// internal seed that advances once per completed frame.
module scrambler_seq
    import scr_pkg::*;
#(
    parameter int LEN_W   = 12,
    parameter int NDBPS_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   psdu_len,
    input  logic [NDBPS_W-1:0] ndbps,
    input  logic [6:0]         seed,
    input  logic [7:0]         byte_data,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic               scr_reset,
    output logic [6:0]         scr_init,
    output logic               scr_din,
    output logic               scr_din_valid,
    output logic               tail_zero,
    output logic               busy,
    output logic               done
);

    localparam logic [4:0] SERVICE_LAST = 5'(SERVICE_BITS - 1);
    localparam logic [4:0] TAIL_LAST    = 5'(TAIL_BITS - 1);

    state_e             state_q;
    logic [4:0]         cnt_q;
    logic [NDBPS_W-1:0] sym_cnt_q;
    logic [NDBPS_W-1:0] ndbps_q;
    logic               len_zero_q;
    logic               tail_zero_q;
    logic [6:0]         scr_init_q;
    logic [6:0]         seed_eff;
    logic               start_acc;
    logic               ser_bit;
    logic               ser_valid;
    logic               ser_last;
    logic               bit_valid;
    logic [NDBPS_W-1:0] sym_inc;
    logic [NDBPS_W-1:0] sym_next;

    assign start_acc = (state_q == ST_IDLE) && start;

`ifdef SCRSEQ_AUTO_SEED_EN
    logic [6:0] auto_seed_q;

    // Rotating seed: consumed at frame start, advanced when a frame completes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_seed_q <= AUTO_SEED_RST;
        end else if (state_q == ST_FLUSH) begin
            auto_seed_q <= lfsr_step(auto_seed_q);
        end
    end

    assign seed_eff = auto_seed_q;
`else
    assign seed_eff = (seed == 7'd0) ? SEED_ZERO_SUB : seed;
`endif

    psdu_serializer #(
        .LEN_W (LEN_W)
    ) u_ser (
        .clk_i        (clock),
        .rst_ni       (reset_n),
        .load_i       (start_acc),
        .len_i        (psdu_len),
        .active_i     (state_q == ST_DATA),
        .byte_data_i  (byte_data),
        .byte_valid_i (byte_valid),
        .byte_ready_o (byte_ready),
        .bit_o        (ser_bit),
        .bit_valid_o  (ser_valid),
        .last_o       (ser_last)
    );

    // Bit validity per state; only DATA can stall.
    always_comb begin
        bit_valid = 1'b0;
        case (state_q)
            ST_SERVICE, ST_TAIL, ST_PAD: bit_valid = 1'b1;
            ST_DATA:                     bit_valid = ser_valid;
            default:                     bit_valid = 1'b0;
        endcase
    end

    // Symbol position after the current bit; ndbps of zero disables padding.
    assign sym_inc  = sym_cnt_q + NDBPS_W'(1);
    assign sym_next = ((ndbps_q == '0) || (sym_inc == ndbps_q)) ? '0 : sym_inc;

    // Frame FSM with its counters and latched frame parameters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 5'd0;
            sym_cnt_q   <= '0;
            ndbps_q     <= '0;
            len_zero_q  <= 1'b0;
            tail_zero_q <= 1'b0;
            scr_init_q  <= SEED_ZERO_SUB;
        end else begin
            tail_zero_q <= (state_q == ST_TAIL);
            if (bit_valid) begin
                sym_cnt_q <= sym_next;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        ndbps_q    <= ndbps;
                        len_zero_q <= (psdu_len == '0);
                        scr_init_q <= seed_eff;
                        sym_cnt_q  <= '0;
                        cnt_q      <= 5'd0;
                        state_q    <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    cnt_q   <= 5'd0;
                    state_q <= ST_SERVICE;
                end
                ST_SERVICE: begin
                    if (cnt_q == SERVICE_LAST) begin
                        cnt_q   <= 5'd0;
                        state_q <= len_zero_q ? ST_TAIL : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_DATA: begin
                    if (ser_last) begin
                        cnt_q   <= 5'd0;
                        state_q <= ST_TAIL;
                    end
                end
                ST_TAIL: begin
                    if (cnt_q == TAIL_LAST) begin
                        cnt_q   <= 5'd0;
                        state_q <= (sym_next == '0) ? ST_FLUSH : ST_PAD;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_PAD: begin
                    if (sym_next == '0) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign scr_reset     = (state_q == ST_INIT);
    assign scr_init      = scr_init_q;
    assign scr_din       = (state_q == ST_DATA) && ser_valid && ser_bit;
    assign scr_din_valid = bit_valid;
    assign tail_zero     = tail_zero_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_scrambler_seq.sv
// Bench for scrambler_seq: table of frame records plus hand-written reset
// and restart sequences. Expected serial bits are queued when a frame is
// started and popped as the sequencer emits valid bits.
module tb_scrambler_seq;

    localparam int LEN_W      = 12;
    localparam int NDBPS_W    = 8;
    localparam int STALL_HOLD = 11;
    localparam int NUM_TC     = 7;

    logic               clock;
    logic               reset_n;
    logic               start;
    logic [LEN_W-1:0]   psdu_len;
    logic [NDBPS_W-1:0] ndbps;
    logic [6:0]         seed;
    logic [7:0]         byte_data;
    logic               byte_valid;
    logic               byte_ready;
    logic               scr_reset;
    logic [6:0]         scr_init;
    logic               scr_din;
    logic               scr_din_valid;
    logic               tail_zero;
    logic               busy;
    logic               done;

    typedef struct {
        logic [LEN_W-1:0]   len;
        logic [NDBPS_W-1:0] ndbps;
        logic [6:0]         seed;
        logic [7:0]         first_byte;
        bit                 stall;
        bit                 restart;
        int                 exp_total;
    } tc_t;

    tc_t        tcs[NUM_TC];
    logic [0:0] exp_q[$];
    logic [7:0] mac_q[$];
    bit         frame_over;
    logic [6:0] model_seed;
    int         n_checks;
    int         n_errors;

    scrambler_seq #(
        .LEN_W   (LEN_W),
        .NDBPS_W (NDBPS_W)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .psdu_len      (psdu_len),
        .ndbps         (ndbps),
        .seed          (seed),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .scr_reset     (scr_reset),
        .scr_init      (scr_init),
        .scr_din       (scr_din),
        .scr_din_valid (scr_din_valid),
        .tail_zero     (tail_zero),
        .busy          (busy),
        .done          (done)
    );

    // Clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] expected_init(input logic [6:0] s);
`ifdef SCRSEQ_AUTO_SEED_EN
        return model_seed;
`else
        return (s == 7'd0) ? 7'h7F : s;
`endif
    endfunction

    // MAC byte source: offers mac_q in order, optionally going quiet after
    // the second byte is taken.
    task automatic mac_driver(input bit do_stall);
        int  accepted;
        int  hold;
        bit  acc;
        accepted = 0;
        hold     = 0;
        while (!frame_over) begin
            byte_valid = (mac_q.size() > 0) && (hold == 0);
            byte_data  = (mac_q.size() > 0) ? mac_q[0] : 8'h00;
            @(negedge clock);
            acc = byte_valid && byte_ready;
            @(posedge clock);
            #1;
            if (acc) begin
                void'(mac_q.pop_front());
                accepted++;
                if (do_stall && accepted == 2) hold = STALL_HOLD;
            end else if (hold > 0) begin
                hold--;
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic run_frame(input tc_t tc);
        logic [7:0] bytes[$];
        logic [7:0] b;
        logic [0:0] e;
        logic [6:0] want_init;
        int cyc, total, stalls, tz_cnt, tz_first, done_cyc, late_busy, exp_stalls;
        bit got_done, ready_early;
        total = 0; stalls = 0; tz_cnt = 0; tz_first = -1; done_cyc = -1;
        late_busy = 0; got_done = 0; ready_early = 0;
        exp_stalls = tc.stall ? 3 : 0;

        bytes.delete();
        for (int i = 0; i < int'(tc.len); i++) begin
            b = (i == 0) ? tc.first_byte : 8'($urandom_range(0, 255));
            bytes.push_back(b);
        end
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
        foreach (bytes[i]) for (int j = 0; j < 8; j++) exp_q.push_back(bytes[i][j]);
        for (int i = 0; i < 6; i++) exp_q.push_back(1'b0);
        if (tc.ndbps != 0)
            while ((exp_q.size() % int'(tc.ndbps)) != 0) exp_q.push_back(1'b0);
        mac_q = bytes;
        want_init = expected_init(tc.seed);

        @(negedge clock);
        psdu_len = tc.len;
        ndbps    = tc.ndbps;
        seed     = tc.seed;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        chk("init_scr_reset", 32'(scr_reset), 32'd1);
        chk("init_scr_init", 32'(scr_init), 32'(want_init));
        chk("init_busy", 32'(busy), 32'd1);
        chk("init_valid", 32'(scr_din_valid), 32'd0);

        frame_over = 1'b0;
        fork
            mac_driver(tc.stall);
            begin
                cyc = 1;
                while (!got_done && cyc < 3000) begin
                    @(negedge clock);
                    cyc++;
                    if (tc.restart && cyc == 30) begin
                        psdu_len = 12'd7;
                        ndbps    = 8'd24;
                        seed     = 7'h01;
                        start    = 1'b1;
                    end else begin
                        start = 1'b0;
                    end
                    if (scr_din_valid) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            chk("extra_bit", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("bit%0d", total - 1), 32'(scr_din), 32'(e));
                        end
                    end else if (!done) begin
                        stalls++;
                    end
                    if (tail_zero) begin
                        tz_cnt++;
                        if (tz_first < 0) tz_first = cyc;
                    end
                    if (byte_ready && cyc < 18) ready_early = 1'b1;
                    if (done) begin
                        got_done = 1'b1;
                        done_cyc = cyc;
                    end
                end
                frame_over = 1'b1;
            end
        join
        start = 1'b0;

        chk("done_seen", 32'(got_done), 32'd1);
        chk("total_bits", 32'(total), 32'(tc.exp_total));
        chk("done_cycle", 32'(done_cyc), 32'(2 + tc.exp_total + exp_stalls));
        chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
        chk("tail_zero_len", 32'(tz_cnt), 32'd6);
        chk("tail_zero_first", 32'(tz_first), 32'(2 + 16 + 8 * int'(tc.len) + exp_stalls + 1));
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("ready_outside_data", 32'(ready_early), 32'd0);
        @(negedge clock);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
        if (got_done) model_seed = {model_seed[5:0], model_seed[6] ^ model_seed[3]};
        if (tc.restart) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (busy || done) late_busy++;
            end
            chk("no_restart", 32'(late_busy), 32'd0);
        end
    endtask

    // Reset asserted while PSDU bits are streaming.
    task automatic reset_mid_frame();
        tc_t rec;
        mac_q = '{8'h12, 8'h34, 8'h56};
        frame_over = 1'b0;
        fork
            mac_driver(1'b0);
            begin
                @(negedge clock);
                psdu_len = 12'd3;
                ndbps    = 8'd24;
                seed     = 7'h22;
                start    = 1'b1;
                @(posedge clock);
                #1 start = 1'b0;
                repeat (22) @(posedge clock);
                #3 reset_n = 1'b0;
                #1;
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_valid", 32'(scr_din_valid), 32'd0);
                chk("abort_ready", 32'(byte_ready), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_scr_init", 32'(scr_init), 32'h7F);
                frame_over = 1'b1;
            end
        join
        model_seed = 7'h5D;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("abort_no_done", 32'(done | busy), 32'd0);
        rec = '{len: 12'd1, ndbps: 8'd24, seed: 7'h33, first_byte: 8'hC3,
                stall: 1'b0, restart: 1'b0, exp_total: 48};
        run_frame(rec);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        model_seed = 7'h5D;
        frame_over = 1'b0;
        reset_n    = 1'b0;
        start      = 1'b0;
        psdu_len   = '0;
        ndbps      = '0;
        seed       = '0;
        byte_data  = '0;
        byte_valid = 1'b0;

        tcs[0] = '{len: 12'd1, ndbps: 8'd24,  seed: 7'h5D, first_byte: 8'hA5, stall: 1'b0, restart: 1'b0, exp_total: 48};
        tcs[1] = '{len: 12'd0, ndbps: 8'd24,  seed: 7'h11, first_byte: 8'h00, stall: 1'b0, restart: 1'b0, exp_total: 24};
        tcs[2] = '{len: 12'd3, ndbps: 8'd24,  seed: 7'h2A, first_byte: 8'h3C, stall: 1'b1, restart: 1'b0, exp_total: 48};
        tcs[3] = '{len: 12'd2, ndbps: 8'd24,  seed: 7'h00, first_byte: 8'hF0, stall: 1'b0, restart: 1'b1, exp_total: 48};
        tcs[4] = '{len: 12'd2, ndbps: 8'd0,   seed: 7'h7F, first_byte: 8'h81, stall: 1'b0, restart: 1'b0, exp_total: 38};
        tcs[5] = '{len: 12'd5, ndbps: 8'd48,  seed: 7'h01, first_byte: 8'h6E, stall: 1'b0, restart: 1'b0, exp_total: 96};
        tcs[6] = '{len: 12'd1, ndbps: 8'd216, seed: 7'h40, first_byte: 8'h5A, stall: 1'b0, restart: 1'b0, exp_total: 216};

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(scr_din_valid), 32'd0);
        chk("rst_din", 32'(scr_din), 32'd0);
        chk("rst_scr_reset", 32'(scr_reset), 32'd0);
        chk("rst_scr_init", 32'(scr_init), 32'h7F);
        chk("rst_tail_zero", 32'(tail_zero), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(byte_ready), 32'd0);

        @(negedge clock);
        reset_n = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        repeat (2) @(negedge clock);
        chk("idle_ready", 32'(byte_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        byte_valid = 1'b0;

        for (int t = 0; t < NUM_TC; t++) begin
            run_frame(tcs[t]);
            repeat ($urandom_range(1, 4)) @(negedge clock);
        end

        reset_mid_frame();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
